// File: rtl/glb_arb_pkg.sv
// Shared types and constants for the GLB access arbiter and its round-robin sub-arbiters.
package glb_arb_pkg;

    localparam int IC_MAX_DEF = 32;
    localparam int OC_MAX_DEF = 32;
    localparam int GLB_ADDR_W = 32;
    localparam int GLB_DATA_W = 32;

    localparam int IC_IDX_W   = $clog2(IC_MAX_DEF);
    localparam int OC_IDX_W   = $clog2(OC_MAX_DEF);
    localparam int LANE_IDX_W = (IC_IDX_W > OC_IDX_W) ? IC_IDX_W : OC_IDX_W;

    localparam logic [3:0] GLB_WEB_READ = 4'hF;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_IFMAP,
        CLS_IPSUM,
        CLS_OPSUM
    } glb_cls_e;

    typedef struct packed {
        logic                  valid;
        glb_cls_e              cls;
        logic [LANE_IDX_W-1:0] idx;
        logic [GLB_ADDR_W-1:0] addr;
        logic [GLB_DATA_W-1:0] wdata;
        logic [3:0]            web;
    } glb_cmd_t;

    // Round-robin successor of a granted lane, wrapping at the lane count.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, searching upward with wrap.
module rr_arbiter #(
    parameter int N     = 32,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any_grant && req[j]) begin
                any_grant = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
        if (any_grant) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/glb_access_arbiter.sv
// Single-port GLB arbiter: one grant per cycle (opsum > ipsum > ifmap), registered command
// stage to the SRAM, and a response stage that returns read data with a permit_push pulse.
module glb_access_arbiter
    import glb_arb_pkg::*;
#(
    parameter int IC_MAX = IC_MAX_DEF,
    parameter int OC_MAX = OC_MAX_DEF,
    parameter int ADDR_W = GLB_ADDR_W,
    parameter int DATA_W = GLB_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IC_MAX-1:0]        ifmap_glb_read_req_i,
    input  logic [ADDR_W*IC_MAX-1:0] ifmap_glb_read_addr_i,
    input  logic [OC_MAX-1:0]        ipsum_glb_read_req_i,
    input  logic [ADDR_W*OC_MAX-1:0] ipsum_glb_read_addr_i,
    input  logic [OC_MAX-1:0]        opsum_glb_write_req_i,
    input  logic [ADDR_W*OC_MAX-1:0] opsum_glb_write_addr_i,
    input  logic [DATA_W*OC_MAX-1:0] opsum_glb_write_data_i,
    input  logic [4*OC_MAX-1:0]      opsum_glb_write_web_i,
    output logic [IC_MAX-1:0]        ifmap_permit_push_o,
    output logic [OC_MAX-1:0]        ipsum_permit_push_o,
    output logic [OC_MAX-1:0]        opsum_permit_pop_o,
    output logic [DATA_W-1:0]        glb_read_data_o,
    output logic                     glb_ce_o,
    output logic [3:0]               glb_web_o,
    output logic [ADDR_W-1:0]        glb_addr_o,
    output logic [DATA_W-1:0]        glb_wdata_o,
    input  logic [DATA_W-1:0]        glb_rdata_i,
    output logic                     glb_busy_o
);

    localparam int IC_W = $clog2(IC_MAX);
    localparam int OC_W = $clog2(OC_MAX);

    logic [IC_MAX-1:0] ifmap_out_q, ifmap_elig, ifmap_gnt;
    logic [OC_MAX-1:0] ipsum_out_q, ipsum_elig, ipsum_gnt;
    logic [OC_MAX-1:0] opsum_gnt;
    logic [IC_W-1:0]   ifmap_ptr_q, ifmap_idx;
    logic [OC_W-1:0]   ipsum_ptr_q, ipsum_idx;
    logic [OC_W-1:0]   opsum_ptr_q, opsum_idx;
    logic              ifmap_any, ipsum_any, opsum_any;
    glb_cls_e          win_cls;
    glb_cmd_t          cmd_q, cmd_d;

    logic                  rsp_valid_q;
    glb_cls_e              rsp_cls_q;
    logic [LANE_IDX_W-1:0] rsp_idx_q;
    logic [DATA_W-1:0]     rdata_q;

    assign ifmap_elig = ifmap_glb_read_req_i & ~ifmap_out_q;
    assign ipsum_elig = ipsum_glb_read_req_i & ~ipsum_out_q;

    rr_arbiter #(.N(IC_MAX), .IDX_W(IC_W)) u_rr_ifmap (
        .req(ifmap_elig), .ptr(ifmap_ptr_q),
        .grant(ifmap_gnt), .grant_idx(ifmap_idx), .any_grant(ifmap_any)
    );

    rr_arbiter #(.N(OC_MAX), .IDX_W(OC_W)) u_rr_ipsum (
        .req(ipsum_elig), .ptr(ipsum_ptr_q),
        .grant(ipsum_gnt), .grant_idx(ipsum_idx), .any_grant(ipsum_any)
    );

    rr_arbiter #(.N(OC_MAX), .IDX_W(OC_W)) u_rr_opsum (
        .req(opsum_glb_write_req_i), .ptr(opsum_ptr_q),
        .grant(opsum_gnt), .grant_idx(opsum_idx), .any_grant(opsum_any)
    );

    always_comb begin
        win_cls = CLS_NONE;
        if (opsum_any)      win_cls = CLS_OPSUM;
        else if (ipsum_any) win_cls = CLS_IPSUM;
        else if (ifmap_any) win_cls = CLS_IFMAP;
    end

    assign opsum_permit_pop_o = (win_cls == CLS_OPSUM) ? opsum_gnt : '0;

    // Idle cycles keep the previous address/data so the SRAM pins only toggle on real commands.
    always_comb begin
        cmd_d       = cmd_q;
        cmd_d.valid = 1'b0;
        unique case (win_cls)
            CLS_OPSUM: begin
                cmd_d.valid = 1'b1;
                cmd_d.cls   = CLS_OPSUM;
                cmd_d.idx   = LANE_IDX_W'(opsum_idx);
                cmd_d.addr  = opsum_glb_write_addr_i[int'(opsum_idx)*ADDR_W +: ADDR_W];
                cmd_d.wdata = opsum_glb_write_data_i[int'(opsum_idx)*DATA_W +: DATA_W];
                cmd_d.web   = opsum_glb_write_web_i[int'(opsum_idx)*4 +: 4];
            end
            CLS_IPSUM: begin
                cmd_d.valid = 1'b1;
                cmd_d.cls   = CLS_IPSUM;
                cmd_d.idx   = LANE_IDX_W'(ipsum_idx);
                cmd_d.addr  = ipsum_glb_read_addr_i[int'(ipsum_idx)*ADDR_W +: ADDR_W];
                cmd_d.web   = GLB_WEB_READ;
            end
            CLS_IFMAP: begin
                cmd_d.valid = 1'b1;
                cmd_d.cls   = CLS_IFMAP;
                cmd_d.idx   = LANE_IDX_W'(ifmap_idx);
                cmd_d.addr  = ifmap_glb_read_addr_i[int'(ifmap_idx)*ADDR_W +: ADDR_W];
                cmd_d.web   = GLB_WEB_READ;
            end
            default: ;
        endcase
    end

    always_comb begin
        ifmap_permit_push_o = '0;
        ipsum_permit_push_o = '0;
        if (rsp_valid_q) begin
            if (rsp_cls_q == CLS_IFMAP)
                ifmap_permit_push_o[rsp_idx_q[IC_W-1:0]] = 1'b1;
            else if (rsp_cls_q == CLS_IPSUM)
                ipsum_permit_push_o[rsp_idx_q[OC_W-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q       <= '{valid: 1'b0, cls: CLS_NONE, idx: '0, addr: '0, wdata: '0,
                             web: GLB_WEB_READ};
            rsp_valid_q <= 1'b0;
            rsp_cls_q   <= CLS_NONE;
            rsp_idx_q   <= '0;
            rdata_q     <= '0;
            ifmap_out_q <= '0;
            ipsum_out_q <= '0;
            ifmap_ptr_q <= '0;
            ipsum_ptr_q <= '0;
            opsum_ptr_q <= '0;
        end else begin
            cmd_q       <= cmd_d;
            rsp_valid_q <= cmd_q.valid && (cmd_q.cls != CLS_OPSUM);
            rsp_cls_q   <= cmd_q.cls;
            rsp_idx_q   <= cmd_q.idx;
            if (rsp_valid_q) rdata_q <= glb_rdata_i;
            ifmap_out_q <= (ifmap_out_q | ((win_cls == CLS_IFMAP) ? ifmap_gnt : '0))
                           & ~ifmap_permit_push_o;
            ipsum_out_q <= (ipsum_out_q | ((win_cls == CLS_IPSUM) ? ipsum_gnt : '0))
                           & ~ipsum_permit_push_o;
            if (win_cls == CLS_IFMAP) ifmap_ptr_q <= IC_W'(rr_next(int'(ifmap_idx), IC_MAX));
            if (win_cls == CLS_IPSUM) ipsum_ptr_q <= OC_W'(rr_next(int'(ipsum_idx), OC_MAX));
            if (win_cls == CLS_OPSUM) opsum_ptr_q <= OC_W'(rr_next(int'(opsum_idx), OC_MAX));
        end
    end

    // SRAM data is live in the push cycle; the captured copy holds it afterwards.
    assign glb_read_data_o = rsp_valid_q ? glb_rdata_i : rdata_q;
    assign glb_ce_o        = cmd_q.valid;
    assign glb_web_o       = cmd_q.valid ? cmd_q.web : GLB_WEB_READ;
    assign glb_addr_o      = cmd_q.addr;
    assign glb_wdata_o     = cmd_q.wdata;
    assign glb_busy_o      = (|ifmap_out_q) | (|ipsum_out_q) | cmd_q.valid;

endmodule
